// File: rtl/vga_timing_analyzer.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_analyzer
// Description : Receive-side VGA timing analyzer on the pixel-clock domain.
//               Measures clocks per line, hsync width, lines per frame and
//               vsync width. Results are published once per frame together
//               with a frame_tick pulse. Lock is declared after LOCK_FRAMES
//               consecutive error-free frames that repeat the previous frame.
//
//               Optional pixel probe: define PIXEL_PROBE_EN to build a
//               column/row tracker that captures the pixel at
//               (probe_x, probe_y) once per frame. Without the macro,
//               probe_pix and probe_valid are tied to 0.
//
// Ports       : clk, reset (async, active-high)
//               hsync, vsync, rrggbb        - sampled video input
//               probe_x, probe_y            - probe coordinate (quasi-static)
//               h_total, h_sync_w           - clocks per line / hsync width
//               v_total, v_sync_w           - lines per frame / vsync width
//               locked, frame_tick          - lock status / frame-start pulse
//               probe_pix, probe_valid      - captured pixel / update pulse
// Parameters  : CNT_W (counter width), SYNC_ACT (sync active level),
//               LOCK_FRAMES (matching frames for lock, 1..7)
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_analyzer #(
    parameter int CNT_W       = 11,
    parameter int SYNC_ACT    = 0,
    parameter int LOCK_FRAMES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hsync,
    input  logic             vsync,
    input  logic [5:0]       rrggbb,
    input  logic [CNT_W-1:0] probe_x,
    input  logic [CNT_W-1:0] probe_y,
    output logic [CNT_W-1:0] h_total,
    output logic [CNT_W-1:0] h_sync_w,
    output logic [CNT_W-1:0] v_total,
    output logic [CNT_W-1:0] v_sync_w,
    output logic             locked,
    output logic             frame_tick,
    output logic [5:0]       probe_pix,
    output logic             probe_valid
);

    localparam logic             c_act    = (SYNC_ACT != 0);
    localparam logic [CNT_W-1:0] c_one    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_sat    = {CNT_W{1'b1}};
    localparam logic [2:0]       c_lock_n = 3'(LOCK_FRAMES);

    typedef enum logic [0:0] {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == c_sat) ? v : v + c_one;
    endfunction

    // Input pipeline: *_q is the registered input, *_q2 one clock older.
    logic       hs_q, hs_q2, vs_q, vs_q2;
    logic [5:0] pix_q;

    logic [CNT_W-1:0] hcnt_q, hcnt_d, hswc_q, hswc_d, hsw_cap_q, hsw_cap_d;
    logic [CNT_W-1:0] line_len_q, line_len_d, vcnt_q, vcnt_d;
    logic [CNT_W-1:0] vswc_q, vswc_d, vsw_cap_q, vsw_cap_d;
    logic [CNT_W-1:0] h_total_q, h_total_d, h_sync_w_q, h_sync_w_d;
    logic [CNT_W-1:0] v_total_q, v_total_d, v_sync_w_q, v_sync_w_d;
    logic             first_line_q, first_line_d, ferr_q, ferr_d;
    logic             have_prev_q, have_prev_d, frame_tick_q, frame_tick_d;
    logic [2:0]       match_q, match_d;
    state_t           state_q, state_d;

    logic w_hs_act, w_hs_asrt, w_hs_deas, w_vs_act, w_vs_asrt, w_vs_deas;
    logic w_err, w_ferr_now, w_same;
    logic [CNT_W-1:0] w_line_new, w_vt_new;

    assign w_hs_act   = (hs_q == c_act);
    assign w_hs_asrt  = w_hs_act && (hs_q2 != c_act);
    assign w_hs_deas  = !w_hs_act && (hs_q2 == c_act);
    assign w_vs_act   = (vs_q == c_act);
    assign w_vs_asrt  = w_vs_act && (vs_q2 != c_act);
    assign w_vs_deas  = !w_vs_act && (vs_q2 == c_act);
    assign w_line_new = sat_inc(hcnt_q);
    // vcnt counts hsync edges after the one that opened the frame, so the
    // opening line is added back here.
    assign w_vt_new   = sat_inc(vcnt_q);

    always_comb begin
        hcnt_d       = hcnt_q;
        hswc_d       = hswc_q;
        hsw_cap_d    = hsw_cap_q;
        line_len_d   = line_len_q;
        vcnt_d       = vcnt_q;
        vswc_d       = vswc_q;
        vsw_cap_d    = vsw_cap_q;
        h_total_d    = h_total_q;
        h_sync_w_d   = h_sync_w_q;
        v_total_d    = v_total_q;
        v_sync_w_d   = v_sync_w_q;
        first_line_d = first_line_q;
        have_prev_d  = have_prev_q;
        match_d      = match_q;
        state_d      = state_q;
        frame_tick_d = 1'b0;
        w_err        = 1'b0;
        w_same       = 1'b0;

        // Horizontal measurement
        hcnt_d = w_hs_asrt ? '0 : sat_inc(hcnt_q);
        if (w_hs_asrt) begin
            hswc_d = c_one;
        end else if (w_hs_act) begin
            hswc_d = sat_inc(hswc_q);
        end
        if (w_hs_deas) begin
            hsw_cap_d = hswc_q;
            if (hswc_q == c_sat) w_err = 1'b1;
        end

        // Line end: processed before any coincident frame boundary so the
        // closing line belongs to the frame that is ending.
        if (w_hs_asrt) begin
            line_len_d   = w_line_new;
            first_line_d = 1'b0;
            if (w_line_new == c_sat) w_err = 1'b1;
            if (!first_line_q && (w_line_new != line_len_q)) w_err = 1'b1;
            vcnt_d = sat_inc(vcnt_q);
            if (w_vs_act) vswc_d = sat_inc(vswc_q);
        end
        if (w_vs_deas) begin
            vsw_cap_d = vswc_q;
            if (vswc_q == c_sat) w_err = 1'b1;
        end
        if (w_vs_asrt && (w_vt_new == c_sat)) w_err = 1'b1;

        w_ferr_now = ferr_q | w_err;
        ferr_d     = w_ferr_now;

        // Frame boundary: publish, compare, advance lock FSM
        if (w_vs_asrt) begin
            h_total_d  = line_len_d;
            h_sync_w_d = hsw_cap_d;
            v_total_d  = w_vt_new;
            v_sync_w_d = vsw_cap_d;
            w_same = have_prev_q && !w_ferr_now &&
                     (h_total_d == h_total_q) && (h_sync_w_d == h_sync_w_q) &&
                     (v_total_d == v_total_q) && (v_sync_w_d == v_sync_w_q);
            frame_tick_d = 1'b1;
            have_prev_d  = 1'b1;
            vcnt_d       = '0;
            vswc_d       = w_hs_asrt ? c_one : '0;
            first_line_d = 1'b1;
            ferr_d       = 1'b0;
            if (!w_same) begin
                state_d = ST_SEARCH;
                match_d = 3'd0;
            end else if (state_q == ST_SEARCH) begin
                match_d = match_q + 3'd1;
                if (match_d == c_lock_n) state_d = ST_LOCKED;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_q <= 1'b0;  hs_q2 <= 1'b0;  vs_q <= 1'b0;  vs_q2 <= 1'b0;
            pix_q        <= '0;
            hcnt_q       <= '0;
            hswc_q       <= '0;
            hsw_cap_q    <= '0;
            line_len_q   <= '0;
            vcnt_q       <= '0;
            vswc_q       <= '0;
            vsw_cap_q    <= '0;
            h_total_q    <= '0;
            h_sync_w_q   <= '0;
            v_total_q    <= '0;
            v_sync_w_q   <= '0;
            first_line_q <= 1'b1;
            ferr_q       <= 1'b0;
            have_prev_q  <= 1'b0;
            frame_tick_q <= 1'b0;
            match_q      <= 3'd0;
            state_q      <= ST_SEARCH;
        end else begin
            hs_q <= hsync;  hs_q2 <= hs_q;  vs_q <= vsync;  vs_q2 <= vs_q;
            pix_q        <= rrggbb;
            hcnt_q       <= hcnt_d;
            hswc_q       <= hswc_d;
            hsw_cap_q    <= hsw_cap_d;
            line_len_q   <= line_len_d;
            vcnt_q       <= vcnt_d;
            vswc_q       <= vswc_d;
            vsw_cap_q    <= vsw_cap_d;
            h_total_q    <= h_total_d;
            h_sync_w_q   <= h_sync_w_d;
            v_total_q    <= v_total_d;
            v_sync_w_q   <= v_sync_w_d;
            first_line_q <= first_line_d;
            ferr_q       <= ferr_d;
            have_prev_q  <= have_prev_d;
            frame_tick_q <= frame_tick_d;
            match_q      <= match_d;
            state_q      <= state_d;
        end
    end

    assign h_total    = h_total_q;
    assign h_sync_w   = h_sync_w_q;
    assign v_total    = v_total_q;
    assign v_sync_w   = v_sync_w_q;
    assign frame_tick = frame_tick_q;
    assign locked     = (state_q == ST_LOCKED);

`ifdef PIXEL_PROBE_EN
    logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
    logic             done_q, done_d, probe_valid_q, probe_valid_d;
    logic [5:0]       probe_pix_q, probe_pix_d;

    // x/y are aligned with pix_q: x == 0 is the pixel after the first
    // hsync-inactive pixel, y == 0 is the line where vsync deasserts.
    always_comb begin
        x_d           = w_hs_deas ? '0 : sat_inc(x_q);
        y_d           = y_q;
        done_d        = done_q;
        probe_pix_d   = probe_pix_q;
        probe_valid_d = 1'b0;
        if (w_vs_deas) begin
            y_d = '0;
        end else if (w_hs_asrt) begin
            y_d = sat_inc(y_q);
        end
        if (w_vs_asrt) begin
            done_d = 1'b0;
        end else if (!done_q && (x_q == probe_x) && (y_q == probe_y)) begin
            probe_pix_d   = pix_q;
            probe_valid_d = 1'b1;
            done_d        = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q           <= '0;
            y_q           <= '0;
            done_q        <= 1'b0;
            probe_pix_q   <= '0;
            probe_valid_q <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            done_q        <= done_d;
            probe_pix_q   <= probe_pix_d;
            probe_valid_q <= probe_valid_d;
        end
    end

    assign probe_pix   = probe_pix_q;
    assign probe_valid = probe_valid_q;
`else
    logic unused_probe;
    assign unused_probe = ^{pix_q, probe_x, probe_y};
    assign probe_pix    = 6'd0;
    assign probe_valid  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/vga_timing_analyzer.md
# vga_timing_analyzer

Receive-side VGA timing analyzer. It samples `hsync`, `vsync` and `rrggbb` on the pixel clock and measures line length, sync widths and lines per frame. It declares lock after consecutive identical frames and can optionally capture the pixel at a programmable coordinate. It sits on the pixel-clock domain beside the VGA clock generator and provides self-check, bring-up and bench observability of its output.

## Interface
- `CNT_W`, 11: width of all counters and measurement outputs.
- `SYNC_ACT`, 0: active level of `hsync`/`vsync` (0 = active-low).
- `LOCK_FRAMES`, 2: consecutive matching frames required for lock (1..7).

- `clk` in 1: pixel clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `hsync` in 1: horizontal sync from the generator, same clock domain.
- `vsync` in 1: vertical sync, same clock domain.
- `rrggbb` in 6: pixel colour.
- `probe_x` in CNT_W: probe column, quasi-static.
- `probe_y` in CNT_W: probe row, quasi-static.
- `h_total` out CNT_W: clocks per line, last published frame.
- `h_sync_w` out CNT_W: hsync active width in clocks.
- `v_total` out CNT_W: lines per frame.
- `v_sync_w` out CNT_W: vsync active width in lines.
- `locked` out 1: timing is stable.
- `frame_tick` out 1: one-cycle pulse per frame start.
- `probe_pix` out 6: captured pixel.
- `probe_valid` out 1: one-cycle pulse when `probe_pix` updates.

## Operation
- Inputs are registered once (`hs_q`, `vs_q`, `pix_q`). Edges are detected from `*_q` versus `*_q2`, where "assert" means transition to `SYNC_ACT`.
- `hcnt` increments every clock and resets to 0 on hsync assert. At that edge, `line_len = hcnt+1` is captured. `hswc` counts clocks while hsync is active and is captured on the deassert edge.
- `vcnt` increments on each hsync assert edge and resets to 0 on vsync assert. `vswc` counts hsync assert edges while vsync is active.
- All counters saturate at all-ones. A saturated capture sets the frame error flag `ferr`.
- Any line length different from the previous line's length within the same frame sets `ferr`. The first line after reset and the first line of each frame are exempt.
- Frame boundary (vsync assert edge):
  - Publish `h_total`, `h_sync_w`, `v_total = vcnt+1`, `v_sync_w`.
  - Pulse `frame_tick`.
  - Compare the new values with the previous published set.
  - Clear `ferr` for the next frame.
- Lock FSM:
  - SEARCH: `locked=0`, `match=0`.
  - Each boundary where the values are equal to the previous set and `ferr=0` increments `match`. Any other boundary sets `match=0`.
  - Enter LOCKED when `match == LOCK_FRAMES`.
  - In LOCKED, any mismatching or errored boundary returns to SEARCH with `match=0` and drops `locked` in the same cycle as `frame_tick`.
  - The first boundary after reset never counts as a match.
- If a vsync edge and an hsync edge occur in the same cycle, the hsync edge is processed first. The line count includes that line.
- Reset values: all outputs 0, FSM in SEARCH, counters 0, `ferr=0`.

## Timing
- An input change at clock edge k is registered at edge k+1. The edge is acted on at edge k+2, so `frame_tick`, published values and `locked` change 2 clocks after `vsync` asserts.
- Published outputs are stable for a whole frame and change only together with `frame_tick`.
- `probe_valid` asserts 2 clocks after the probed pixel is presented on `rrggbb`.
- Reset asserted mid-frame clears everything immediately. Measurement restarts at the next vsync assert edge; the partial frame is discarded.

## Configuration
- `PIXEL_PROBE_EN` defined:
  - The column counter `x` resets to 0 on the hsync deassert edge and increments per clock.
  - The row counter `y` resets to 0 on the vsync deassert edge and increments per hsync assert.
  - When `x==probe_x` and `y==probe_y`, `pix_q` is latched into `probe_pix` and `probe_valid` pulses, at most once per frame.
- Not defined: no probe logic is built; `probe_pix` ties to 0 and `probe_valid` to 0.

## Test plan
- Small mode (`h_total` 20, hsync 3, `v_total` 10, vsync 2, active-low), 4 frames -> `frame_tick` every 200 clocks; `h_total`=20, `h_sync_w`=3, `v_total`=10, `v_sync_w`=2; `locked` rises at the 3rd boundary.
- 640x480@72 timing (832 clocks/line, hsync 40, 520 lines, vsync 3) -> values 832/40/520/3 and lock after 3 frames.
- Lock, then one line lengthened to 21 clocks -> `locked` drops at the next `frame_tick`; relocks after 2 further clean frames.
- Hold hsync inactive for 2100 clocks with CNT_W=11 -> saturation; `ferr` set; `locked` stays 0 at that boundary.
- Assert reset mid-frame while locked -> all outputs 0 immediately; first post-reset boundary publishes values with `locked`=0.
- With `PIXEL_PROBE_EN`, `probe_x`=5, `probe_y`=3, `rrggbb`=6'b101101 only at that pixel -> `probe_pix`=6'b101101 and a single `probe_valid` per frame, 2 clocks after that pixel.
